// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: captures one frame of per-lane intensities through a
// valid/ready handshake, then emits one registered spike vector per enabled
// timestep until num_steps steps have been produced, flagging the last with done.
//
// Optional build macro: SPIKE_ENCODER_LFSR_EN
//   undefined -> deterministic mode: per-lane phase accumulators, spike = carry
//   defined   -> stochastic mode: spike when intensity exceeds an LFSR threshold
//
// Handshake: a frame transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE. in_valid seen outside IDLE is ignored and the
// source keeps holding the frame.
module spike_rate_encoder #(
    parameter int          num_inputs      = 4,
    parameter int          intensity_width = 8,
    parameter int          num_steps       = 100,
    parameter logic [15:0] lfsr_seed       = 16'hACE1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [num_inputs*intensity_width-1:0] in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  step_en,
    output logic [num_inputs-1:0]                 spike_out,
    output logic                                  step_valid,
    output logic                                  busy,
    output logic                                  done
);
    localparam int W     = intensity_width;
    localparam int NI    = num_inputs;
    localparam int CNT_W = $clog2(num_steps + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(num_steps - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NI*W-1:0]    frame_q, frame_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NI-1:0]      spike_q, spike_d;
    logic               step_valid_q, step_valid_d;
    logic               done_q, done_d;
    logic [NI-1:0]      lane_hit;
    logic               accept;
    logic               step;

    assign accept = (state_q == S_IDLE) && in_valid;
    assign step   = (state_q == S_RUN) && step_en;

`ifdef SPIKE_ENCODER_LFSR_EN
    // Mask selecting the low W bits of the rotated LFSR value as a threshold.
    localparam logic [16:0] THR_MASK = (17'd1 << W) - 17'd1;

    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Fibonacci feedback for taps 16,14,13,11.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    for (genvar g = 0; g < NI; g++) begin : g_lane
        localparam int R = g % 16;
        logic [15:0] rot;
        if (R == 0) begin : g_norot
            assign rot = lfsr_q;
        end else begin : g_rot
            assign rot = (lfsr_q << R) | (lfsr_q >> (16 - R));
        end
        assign lane_hit[g] = 16'(frame_q[g*W +: W]) > (rot & THR_MASK[15:0]);
    end

    // LFSR reloads on frame acceptance and advances once per enabled step.
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = lfsr_seed;
        end else if (step) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end
    end

    // LFSR register, seeded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= lfsr_seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // Accumulators keep W bits; the sum is W+1 bits so bit W is the carry spike.
    logic [NI-1:0][W-1:0] acc_q, acc_d;
    logic [NI-1:0][W:0]   acc_sum;

    for (genvar g = 0; g < NI; g++) begin : g_lane
        assign acc_sum[g]  = {1'b0, acc_q[g]} + {1'b0, frame_q[g*W +: W]};
        assign lane_hit[g] = acc_sum[g][W];
    end

    // Accumulators clear on acceptance and wrap-add the intensity per step.
    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            acc_d = '0;
        end else if (step) begin
            for (int i = 0; i < NI; i++) begin
                acc_d[i] = acc_sum[i][W-1:0];
            end
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    // Next-state and registered-output logic for the IDLE/RUN frame FSM.
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        cnt_d        = cnt_q;
        spike_d      = '0;
        step_valid_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    frame_d = in_data;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (step_en) begin
                    spike_d      = lane_hit;
                    step_valid_d = 1'b1;
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, frame, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            frame_q      <= '0;
            cnt_q        <= '0;
            spike_q      <= '0;
            step_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            cnt_q        <= cnt_d;
            spike_q      <= spike_d;
            step_valid_q <= step_valid_d;
            done_q       <= done_d;
        end
    end

    assign spike_out  = spike_q;
    assign step_valid = step_valid_q;
    assign done       = done_q;
    assign busy       = (state_q == S_RUN);
    assign in_ready   = (state_q == S_IDLE);

endmodule
